// File: rtl/gpu_cmd_queue_decoder.sv
// gpu_cmd_queue_decoder
//   Decodes {opcode, parameters} commands from the APB slave. It keeps shadow
//   coordinate and radius registers and packs each draw command into a
//   self-contained instruction. Instructions are queued in a DEPTH-entry
//   show-ahead FIFO that the rasterizer drains over a valid/ready handshake.
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   command_i           command strobe; accepted when command_i && cmd_ready_o
//   opcode_i            4-bit opcode
//   parameters_i        28-bit command parameters
//   cmd_ready_o         command can be accepted this cycle
//   inst_valid_o        FIFO head valid
//   inst_ready_i        rasterizer consumes the head when inst_valid_o is high
//   opcode_o .. b_o     head instruction fields
//   fifo_count_o        occupied FIFO entries
//   err_o               sticky illegal-opcode flag
module gpu_cmd_queue_decoder #(
    parameter int WIDTH_BITS   = 10,
    parameter int HEIGHT_BITS  = 9,
    parameter int CHANNEL_BITS = 8,
    parameter int DEPTH        = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         command_i,
    input  logic [3:0]                   opcode_i,
    input  logic [27:0]                  parameters_i,
    output logic                         cmd_ready_o,
    output logic                         inst_valid_o,
    input  logic                         inst_ready_i,
    output logic [3:0]                   opcode_o,
    output logic [WIDTH_BITS-1:0]        x1_o,
    output logic [WIDTH_BITS-1:0]        x2_o,
    output logic [HEIGHT_BITS-1:0]      y1_o,
    output logic [HEIGHT_BITS-1:0]      y2_o,
    output logic [WIDTH_BITS-1:0]        rad_o,
    output logic [2:0]                   oct_o,
    output logic [CHANNEL_BITS-1:0]      r_o,
    output logic [CHANNEL_BITS-1:0]      g_o,
    output logic [CHANNEL_BITS-1:0]      b_o,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count_o,
    output logic                         err_o
);
    localparam int W  = WIDTH_BITS;
    localparam int H  = HEIGHT_BITS;
    localparam int C  = CHANNEL_BITS;
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [3:0] OP_FLUSH = 4'h0, OP_SETXY1 = 4'h1, OP_SETXY2 = 4'h2,
                           OP_SETRAD = 4'h3, OP_LINE = 4'h4, OP_RECT = 4'h5,
                           OP_CIRCLE = 4'h6, OP_ARC = 4'h7, OP_CLEAR = 4'h8;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] x1;
        logic [W-1:0] x2;
        logic [H-1:0] y1;
        logic [H-1:0] y2;
        logic [W-1:0] rad;
        logic [2:0]   oct;
        logic [C-1:0] r;
        logic [C-1:0] g;
        logic [C-1:0] b;
    } entry_t;

    logic [W-1:0]  x1_q, x1_d, x2_q, x2_d, rad_q, rad_d;
    logic [H-1:0]  y1_q, y1_d, y2_q, y2_d;
    logic [C-1:0]  lr_q, lr_d, lg_q, lg_d, lb_q, lb_d;
    logic          err_q, err_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    entry_t        mem_q [DEPTH];
    entry_t        new_e, head_e;
    logic          accept, push, pop, flush;

    // Only some parameter bits are used for any given opcode/parameter set.
    wire unused_params = ^parameters_i;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    // FLUSH bypasses the full check so a stalled queue can always be cleared.
    assign cmd_ready_o  = (count_q < CW'(DEPTH)) || (opcode_i == OP_FLUSH);
    assign accept       = command_i && cmd_ready_o;
    assign inst_valid_o = (count_q != '0);
    assign pop          = inst_valid_o && inst_ready_i && !flush;

    always_comb begin
        x1_d  = x1_q;  y1_d = y1_q;  x2_d = x2_q;  y2_d = y2_q;  rad_d = rad_q;
        lr_d  = lr_q;  lg_d = lg_q;  lb_d = lb_q;  err_d = err_q;
        push  = 1'b0;
        flush = 1'b0;
        new_e = '{op: opcode_i, x1: x1_q, x2: x2_q, y1: y1_q, y2: y2_q, rad: rad_q,
                  oct: 3'd0, r: parameters_i[3*C-1:2*C], g: parameters_i[2*C-1:C],
                  b: parameters_i[C-1:0]};
        if (accept) begin
            case (opcode_i)
                OP_FLUSH: begin
                    flush = 1'b1;
                    x1_d = '0; y1_d = '0; x2_d = '0; y2_d = '0; rad_d = '0;
                    lr_d = '0; lg_d = '0; lb_d = '0; err_d = 1'b0;
                end
                OP_SETXY1: begin
                    x1_d = parameters_i[W-1:0];
                    y1_d = parameters_i[W+H-1:W];
                end
                OP_SETXY2: begin
                    x2_d = parameters_i[W-1:0];
                    y2_d = parameters_i[W+H-1:W];
                end
                OP_SETRAD: rad_d = parameters_i[W-1:0];
                OP_LINE, OP_RECT, OP_CIRCLE, OP_ARC: begin
                    push = 1'b1;
                    lr_d = new_e.r; lg_d = new_e.g; lb_d = new_e.b;
                    if (opcode_i == OP_ARC) new_e.oct = parameters_i[3*C+2:3*C];
                end
                OP_CLEAR: begin
                    push    = 1'b1;
                    new_e.r = lr_q; new_e.g = lg_q; new_e.b = lb_q;
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1_q <= '0; y1_q <= '0; x2_q <= '0; y2_q <= '0; rad_q <= '0;
            lr_q <= '0; lg_q <= '0; lb_q <= '0; err_q <= 1'b0;
        end else begin
            x1_q <= x1_d; y1_q <= y1_d; x2_q <= x2_d; y2_q <= y2_d; rad_q <= rad_d;
            lr_q <= lr_d; lg_q <= lg_d; lb_q <= lb_d; err_q <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: the head is masked to zero whenever empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= new_e;
    end

    assign head_e       = inst_valid_o ? mem_q[rd_ptr_q] : '0;
    assign opcode_o     = head_e.op;
    assign x1_o         = head_e.x1;
    assign x2_o         = head_e.x2;
    assign y1_o         = head_e.y1;
    assign y2_o         = head_e.y2;
    assign rad_o        = head_e.rad;
    assign oct_o        = head_e.oct;
    assign r_o          = head_e.r;
    assign g_o          = head_e.g;
    assign b_o          = head_e.b;
    assign fifo_count_o = count_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_gpu_cmd_queue_decoder.sv
// Bench for gpu_cmd_queue_decoder: directed scenarios followed by random
// commands, all compared against a queue-based reference model.
module tb_gpu_cmd_queue_decoder;
    localparam int W = 10, H = 9, C = 8, DEPTH = 4, CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] x1;
        logic [W-1:0] x2;
        logic [H-1:0] y1;
        logic [H-1:0] y2;
        logic [W-1:0] rad;
        logic [2:0]   oct;
        logic [C-1:0] r;
        logic [C-1:0] g;
        logic [C-1:0] b;
    } entry_t;

    logic clk = 1'b0, rst = 1'b1;
    logic command_i = 1'b0, inst_ready_i = 1'b0;
    logic [3:0] opcode_i = '0;
    logic [27:0] parameters_i = '0;
    logic cmd_ready_o, inst_valid_o, err_o;
    logic [3:0] opcode_o;
    logic [W-1:0] x1_o, x2_o, rad_o;
    logic [H-1:0] y1_o, y2_o;
    logic [2:0] oct_o;
    logic [C-1:0] r_o, g_o, b_o;
    logic [CW-1:0] fifo_count_o;

    gpu_cmd_queue_decoder #(.WIDTH_BITS(W), .HEIGHT_BITS(H), .CHANNEL_BITS(C), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .command_i(command_i), .opcode_i(opcode_i),
        .parameters_i(parameters_i), .cmd_ready_o(cmd_ready_o), .inst_valid_o(inst_valid_o),
        .inst_ready_i(inst_ready_i), .opcode_o(opcode_o), .x1_o(x1_o), .x2_o(x2_o),
        .y1_o(y1_o), .y2_o(y2_o), .rad_o(rad_o), .oct_o(oct_o), .r_o(r_o), .g_o(g_o),
        .b_o(b_o), .fifo_count_o(fifo_count_o), .err_o(err_o));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model state
    entry_t m_q[$];
    int mx1, my1, mx2, my2, mrad, mr, mg, mb;
    bit merr;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic entry_t dut_head();
        entry_t e;
        e = '{op: opcode_o, x1: x1_o, x2: x2_o, y1: y1_o, y2: y2_o, rad: rad_o,
              oct: oct_o, r: r_o, g: g_o, b: b_o};
        return e;
    endfunction

    task automatic model_reset();
        m_q.delete();
        mx1 = 0; my1 = 0; mx2 = 0; my2 = 0; mrad = 0; mr = 0; mg = 0; mb = 0; merr = 0;
    endtask

    task automatic model_update(input bit acc, input int op, input int p, input bit rdy);
        entry_t e;
        bit popit;
        popit = (m_q.size() != 0) && rdy;
        if (acc && op == 0) begin
            model_reset();
            return;
        end
        if (popit) void'(m_q.pop_front());
        if (!acc) return;
        if (op == 1) begin mx1 = p % (1 << W); my1 = (p >> W) % (1 << H); end
        else if (op == 2) begin mx2 = p % (1 << W); my2 = (p >> W) % (1 << H); end
        else if (op == 3) mrad = p % (1 << W);
        else if (op >= 4 && op <= 8) begin
            if (op != 8) begin
                mb = p % 256; mg = (p >> 8) % 256; mr = (p >> 16) % 256;
            end
            e.op = 4'(op);
            e.x1 = W'(mx1); e.y1 = H'(my1); e.x2 = W'(mx2); e.y2 = H'(my2);
            e.rad = W'(mrad);
            e.oct = (op == 7) ? 3'((p >> 24) % 8) : 3'd0;
            e.r = C'(mr); e.g = C'(mg); e.b = C'(mb);
            m_q.push_back(e);
        end else merr = 1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ":count"}, 128'(fifo_count_o), 128'(m_q.size()));
        chk({tag, ":valid"}, 128'(inst_valid_o), 128'(m_q.size() != 0));
        chk({tag, ":err"}, 128'(err_o), 128'(merr));
        if (m_q.size() != 0) chk({tag, ":head"}, 128'(dut_head()), 128'(m_q[0]));
    endtask

    // One clock cycle: drive inputs, check ready, clock, advance model, check outputs.
    task automatic step(input string tag, input bit cmd, input int op, input int p, input bit rdy);
        bit exp_ready;
        command_i = cmd; opcode_i = 4'(op); parameters_i = 28'(p); inst_ready_i = rdy;
        #1;
        exp_ready = (m_q.size() < DEPTH) || (op == 0);
        chk({tag, ":ready"}, 128'(cmd_ready_o), 128'(exp_ready));
        @(posedge clk);
        model_update(cmd && exp_ready, op, p, rdy);
        #1;
        check_state(tag);
    endtask

    initial begin
        model_reset();
        // Reset state
        #1;
        chk("rst:ready", 128'(cmd_ready_o), 128'(1));
        check_state("rst");
        chk("rst:head0", 128'(dut_head()), 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) step("idle", 0, 0, 0, 0);
        chk("idle:head0", 128'(dut_head()), 128'(0));

        // Draw line
        step("xy1", 1, 1, 'h5064, 0);
        step("xy2", 1, 2, 'h3212C, 0);
        step("line", 1, 4, 'hFF8040, 0);
        chk("line:op", 128'(opcode_o), 128'(4));
        chk("line:x1", 128'(x1_o), 128'(100));
        chk("line:y1", 128'(y1_o), 128'(20));
        chk("line:x2", 128'(x2_o), 128'(300));
        chk("line:y2", 128'(y2_o), 128'(200));
        chk("line:rgb", 128'({r_o, g_o, b_o}), 128'(24'hFF8040));
        chk("line:oct", 128'(oct_o), 128'(0));
        step("drain", 0, 0, 0, 1);

        // Arc then clear (clear pops the arc in the same cycle)
        step("arc", 1, 7, 'h5112233, 0);
        chk("arc:oct", 128'(oct_o), 128'(5));
        chk("arc:rgb", 128'({r_o, g_o, b_o}), 128'(24'h112233));
        step("clear", 1, 8, 'hABCDEF, 1);
        chk("clear:op", 128'(opcode_o), 128'(8));
        chk("clear:rgb", 128'({r_o, g_o, b_o}), 128'(24'h112233));
        step("drain", 0, 0, 0, 1);

        // Back-pressure
        step("rad", 1, 3, 'h3FF, 0);
        for (int i = 0; i < 4; i++) step("bp_fill", 1, 4 + i, $urandom, 0);
        chk("bp:full", 128'(fifo_count_o), 128'(4));
        step("bp_hold", 1, 5, 'h123456, 0);
        chk("bp:stall", 128'(cmd_ready_o), 128'(0));
        step("bp_pop", 1, 5, 'h123456, 1);
        chk("bp:cnt3", 128'(fifo_count_o), 128'(3));
        step("bp_acc", 1, 5, 'h123456, 1);
        chk("bp:cnt3b", 128'(fifo_count_o), 128'(3));
        for (int i = 0; i < 4; i++) step("bp_drain", 0, 0, 0, 1);
        chk("bp:empty", 128'(inst_valid_o), 128'(0));

        // Illegal opcode and flush
        for (int i = 0; i < 3; i++) step("il_fill", 1, 6, $urandom, 0);
        step("illegal", 1, 'hA, 0, 0);
        chk("illegal:err", 128'(err_o), 128'(1));
        chk("illegal:cnt", 128'(fifo_count_o), 128'(3));
        step("il_fill4", 1, 4, $urandom, 0);
        step("flush", 1, 0, 0, 1);
        chk("flush:cnt", 128'(fifo_count_o), 128'(0));
        chk("flush:err", 128'(err_o), 128'(0));
        step("post_flush", 1, 5, 'h010203, 0);
        chk("flush:shadow", 128'({x1_o, y1_o, x2_o, y2_o, rad_o}), 128'(0));
        step("flush2", 1, 0, 0, 0);

        // Reset mid-stream with a command pending
        for (int i = 0; i < 3; i++) step("rs_fill", 1, 4, $urandom, 0);
        command_i = 1'b1; opcode_i = 4'h4; parameters_i = 28'h0AAAAAA; inst_ready_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst:valid", 128'(inst_valid_o), 128'(0));
        chk("midrst:cnt", 128'(fifo_count_o), 128'(0));
        model_reset();
        @(posedge clk); #1;
        check_state("midrst_hold");
        @(negedge clk) begin rst = 1'b0; command_i = 1'b0; end
        @(posedge clk); #1;
        check_state("midrst_rel");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            int op, r;
            r = $urandom_range(0, 99);
            if (r < 3) op = 0;
            else if (r < 30) op = $urandom_range(1, 3);
            else if (r < 90) op = $urandom_range(4, 8);
            else op = $urandom_range(9, 15);
            step("rand", 1'($urandom_range(0, 3) != 0), op, $urandom, 1'($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
